line_formador: RTL and testbench

- Refill-line builder for the cache datapath. It sits directly downstream of the cache Control FSM and is driven by `Clear_Formador` / `Eneable_Formador`.
- On a miss it fetches `WORDS_PER_LINE` consecutive words from main memory over a req/ack handshake. It assembles them into one full cache line and presents that line to the data/tag banks with a one-cycle `Line_Ready` strobe.
- It also reports `Busy` back to Control so the FSM can stall until the refill completes.

---
 rtl/line_formador.sv | 161 ++++++++++++++++
 tb/tb_line_formador.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_formador.sv
// line_formador: refill-line builder for the cache datapath.
// Fetches WORDS_PER_LINE consecutive memory words over a req/ack handshake,
// assembles them into one cache line and strobes Line_Ready for one cycle.
// Optional feature macro: LINE_FORMADOR_CWF_EN (critical word first + Crit_Valid).
module line_formador #(
   parameter int unsigned WORD_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic                               CLK,
   input  logic                               RST_N,
   input  logic                               Clear_Formador,
   input  logic                               Eneable_Formador,
   input  logic [ADDR_W-1:0]                  Miss_Addr,
   output logic                               Mem_Req,
   output logic [ADDR_W-1:0]                  Mem_Addr,
   input  logic                               Mem_Ack,
   input  logic [WORD_W-1:0]                  Mem_Data,
   output logic [WORD_W*WORDS_PER_LINE-1:0]   Line_Out,
   output logic                               Line_Ready,
   output logic                               Busy,
`ifdef LINE_FORMADOR_CWF_EN
   output logic                               Crit_Valid,
`endif
   output logic [$clog2(WORDS_PER_LINE):0]    Word_Cnt
);

   localparam int unsigned WB     = WORD_W / 8;
   localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
   localparam int unsigned IDX_W  = $clog2(WORDS_PER_LINE);
   localparam int unsigned CNT_W  = IDX_W + 1;
   localparam int unsigned OFF_W  = $clog2(WB * WORDS_PER_LINE);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_base;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [LINE_W-1:0]   r_line;
   logic                r_req;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_ready;
   logic                r_busy;
   logic                r_crit;

   logic [ADDR_W-1:0]   w_base_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [LINE_W-1:0]   w_line_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_crit_nxt;
   logic                w_ack;
   logic [ADDR_W-1:0]   w_miss_base;
   logic [IDX_W-1:0]    w_first_idx;

   // Acks only count while a request is outstanding
   assign w_ack       = Mem_Ack & r_req;
   assign w_miss_base = Miss_Addr & ~OFF_MASK;

   // Starting word index of a refill
`ifdef LINE_FORMADOR_CWF_EN
   assign w_first_idx = IDX_W'(Miss_Addr / ADDR_W'(WB));
`else
   assign w_first_idx = '0;
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and next datapath values; clear overrides start and ack
   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_line_nxt  = r_line;
      w_crit_nxt  = 1'b0;
      if (Clear_Formador) begin
         w_state_nxt = IDLE;
         w_line_nxt  = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Eneable_Formador) begin
                  w_base_nxt  = w_miss_base;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = w_first_idx;
                  w_state_nxt = FETCH;
               end
            end
            FETCH: begin
               if (w_ack) begin
                  for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
                     if (r_idx == IDX_W'(i)) w_line_nxt[i*WORD_W +: WORD_W] = Mem_Data;
                  end
                  w_cnt_nxt  = r_cnt + CNT_W'(1);
                  w_idx_nxt  = r_idx + IDX_W'(1);
                  w_crit_nxt = (r_cnt == '0);
                  if (r_cnt == CNT_W'(WORDS_PER_LINE - 1)) w_state_nxt = DONE;
               end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Request address follows the next word index
   assign w_addr_nxt = w_base_nxt + ADDR_W'(w_idx_nxt) * ADDR_W'(WB);

   // Datapath and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_base  <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_line  <= '0;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_crit  <= 1'b0;
      end else begin
         r_base  <= w_base_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_line  <= w_line_nxt;
         r_req   <= (w_state_nxt == FETCH);
         r_addr  <= w_addr_nxt;
         r_ready <= (w_state_nxt == DONE);
         r_busy  <= (w_state_nxt != IDLE);
         r_crit  <= w_crit_nxt;
      end
   end

   assign Mem_Req    = r_req;
   assign Mem_Addr   = r_addr;
   assign Line_Out   = r_line;
   assign Line_Ready = r_ready;
   assign Busy       = r_busy;
   assign Word_Cnt   = r_cnt;
`ifdef LINE_FORMADOR_CWF_EN
   assign Crit_Valid = r_crit;
`else
   logic w_unused;
   assign w_unused = r_crit;
`endif

endmodule

// File: tb/tb_line_formador.sv
// Directed bench for line_formador (default geometry: 32-bit words, 4 words/line).
module tb_line_formador;

   logic          CLK;
   logic          RST_N;
   logic          Clear_Formador;
   logic          Eneable_Formador;
   logic [31:0]   Miss_Addr;
   logic          Mem_Req;
   logic [31:0]   Mem_Addr;
   logic          Mem_Ack;
   logic [31:0]   Mem_Data;
   logic [127:0]  Line_Out;
   logic          Line_Ready;
   logic          Busy;
   logic [2:0]    Word_Cnt;
`ifdef LINE_FORMADOR_CWF_EN
   logic          Crit_Valid;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   line_formador dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .Clear_Formador   (Clear_Formador),
      .Eneable_Formador (Eneable_Formador),
      .Miss_Addr        (Miss_Addr),
      .Mem_Req          (Mem_Req),
      .Mem_Addr         (Mem_Addr),
      .Mem_Ack          (Mem_Ack),
      .Mem_Data         (Mem_Data),
      .Line_Out         (Line_Out),
      .Line_Ready       (Line_Ready),
      .Busy             (Busy),
`ifdef LINE_FORMADOR_CWF_EN
      .Crit_Valid       (Crit_Valid),
`endif
      .Word_Cnt         (Word_Cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // One clock edge; return at the following falling edge
   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Expected address of the n-th request of a refill for miss address m
   function automatic logic [31:0] exp_addr(input logic [31:0] m, input int n);
      logic [31:0] base;
      int k;
      base = m & 32'hFFFF_FFF0;
`ifdef LINE_FORMADOR_CWF_EN
      k = int'((m >> 2) & 32'h3);
`else
      k = 0;
`endif
      return base + 32'(((k + n) % 4) * 4);
   endfunction

   function automatic logic [127:0] exp_line(input logic [31:0] m);
      logic [31:0] b;
      b = m & 32'hFFFF_FFF0;
      return {b + 32'hC, b + 32'h8, b + 32'h4, b};
   endfunction

   // Full refill; lat = idle cycles before each ack (0 = back-to-back);
   // intrude = word index at which a foreign enable (0x2000) is pulsed, -1 = none
   task automatic do_fill(input logic [31:0] m, input int lat, input int intrude);
      Miss_Addr        = m;
      Eneable_Formador = 1'b1;
      tick();
      Eneable_Formador = 1'b0;
      chk("start_req",  {127'd0, Mem_Req}, 128'd1);
      chk("start_busy", {127'd0, Busy},    128'd1);
      chk("start_cnt",  {125'd0, Word_Cnt}, 128'd0);
      for (int w = 0; w < 4; w++) begin
         if (lat > 0) begin
            Mem_Ack = 1'b0;
            repeat (lat) tick();
         end
         chk($sformatf("addr%0d", w), {96'd0, Mem_Addr}, {96'd0, exp_addr(m, w)});
         chk($sformatf("req%0d", w),  {127'd0, Mem_Req}, 128'd1);
         Mem_Ack  = 1'b1;
         Mem_Data = exp_addr(m, w);
         if (w == intrude) begin
            Miss_Addr        = 32'h2000;
            Eneable_Formador = 1'b1;
         end
         tick();
         Eneable_Formador = 1'b0;
         chk($sformatf("cnt%0d", w), {125'd0, Word_Cnt}, 128'(w + 1));
`ifdef LINE_FORMADOR_CWF_EN
         chk($sformatf("crit%0d", w), {127'd0, Crit_Valid}, (w == 0) ? 128'd1 : 128'd0);
`endif
         if (w < 3) chk($sformatf("nordy%0d", w), {127'd0, Line_Ready}, 128'd0);
      end
      Mem_Ack = 1'b0;
      chk("done_rdy",  {127'd0, Line_Ready}, 128'd1);
      chk("done_busy", {127'd0, Busy},       128'd1);
      chk("done_req",  {127'd0, Mem_Req},    128'd0);
      chk("done_line", Line_Out, exp_line(m));
      tick();
      chk("post_rdy",  {127'd0, Line_Ready}, 128'd0);
      chk("post_busy", {127'd0, Busy},       128'd0);
      chk("post_line", Line_Out, exp_line(m));
   endtask

   initial begin
      logic seen_rdy;
      RST_N            = 1'b0;
      Clear_Formador   = 1'b0;
      Eneable_Formador = 1'b0;
      Miss_Addr        = '0;
      Mem_Ack          = 1'b0;
      Mem_Data         = '0;
      #3;
      chk("rst_req",  {127'd0, Mem_Req},    128'd0);
      chk("rst_addr", {96'd0, Mem_Addr},    128'd0);
      chk("rst_line", Line_Out,             128'd0);
      chk("rst_rdy",  {127'd0, Line_Ready}, 128'd0);
      chk("rst_busy", {127'd0, Busy},       128'd0);
      chk("rst_cnt",  {125'd0, Word_Cnt},   128'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();

      // Basic fill, acks two cycles after each request
      do_fill(32'h0000_1234, 2, -1);
      chk("basic_line_const", Line_Out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});

      // Stray ack while idle: line and count unchanged
      Mem_Ack  = 1'b1;
      Mem_Data = 32'hDEAD_BEEF;
      tick();
      Mem_Ack  = 1'b0;
      chk("stray_line", Line_Out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
      chk("stray_cnt",  {125'd0, Word_Cnt}, 128'd4);
      chk("stray_busy", {127'd0, Busy},     128'd0);

      // Back-to-back acks
      do_fill(32'h0000_5670, 0, -1);

      // Enable during a fill is ignored
      do_fill(32'h0000_1230, 1, 1);

      // Clear together with the third ack
      Miss_Addr        = 32'h0000_1234;
      Eneable_Formador = 1'b1;
      tick();
      Eneable_Formador = 1'b0;
      for (int w = 0; w < 2; w++) begin
         tick();
         Mem_Ack  = 1'b1;
         Mem_Data = 32'hAAAA_0000 + 32'(w);
         tick();
         Mem_Ack  = 1'b0;
      end
      chk("clr_pre_cnt", {125'd0, Word_Cnt}, 128'd2);
      Mem_Ack        = 1'b1;
      Mem_Data       = 32'hBBBB_BBBB;
      Clear_Formador = 1'b1;
      tick();
      Mem_Ack        = 1'b0;
      Clear_Formador = 1'b0;
      chk("clr_req",  {127'd0, Mem_Req},  128'd0);
      chk("clr_line", Line_Out,           128'd0);
      chk("clr_cnt",  {125'd0, Word_Cnt}, 128'd0);
      chk("clr_busy", {127'd0, Busy},     128'd0);
      seen_rdy = Line_Ready;
      repeat (4) begin
         tick();
         seen_rdy = seen_rdy | Line_Ready;
      end
      chk("clr_no_rdy", {127'd0, seen_rdy}, 128'd0);

      // Async reset mid-fill, then late ack after release
      Miss_Addr        = 32'h0000_1234;
      Eneable_Formador = 1'b1;
      tick();
      Eneable_Formador = 1'b0;
      Mem_Ack  = 1'b1;
      Mem_Data = 32'h1111_1111;
      tick();
      Mem_Ack  = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_req",  {127'd0, Mem_Req},    128'd0);
      chk("arst_addr", {96'd0, Mem_Addr},    128'd0);
      chk("arst_line", Line_Out,             128'd0);
      chk("arst_busy", {127'd0, Busy},       128'd0);
      chk("arst_cnt",  {125'd0, Word_Cnt},   128'd0);
      Mem_Ack = 1'b1;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      chk("late_ack_cnt",  {125'd0, Word_Cnt}, 128'd0);
      chk("late_ack_line", Line_Out,           128'd0);
      do_fill(32'h0000_0040, 1, -1);

`ifdef LINE_FORMADOR_CWF_EN
      // Critical word first from 0x1238
      do_fill(32'h0000_1238, 1, -1);
      chk("cwf_line_const", Line_Out, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
